// File: rtl/mem_pkg.sv
// Shared widths, state encoding and address helper for the data/instruction RAM.
package mem_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 2 ** ADDR_W;

    // Clear sequencer states: CLEAR zero-fills the array, RUN serves accesses.
    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } memState_e;

    // Word index from a full 16-bit address; upper bits alias modulo DEPTH.
    function automatic logic [ADDR_W-1:0] memIndex(input logic [15:0] addr);
        return addr[ADDR_W-1:0];
    endfunction

endpackage

// File: rtl/memory_if.sv
// Processor-side bus of the RAM.
// Handshake: Ready is the slave's accept qualifier. A write takes effect on a
// rising edge only when Ready && MemWrite; while Ready is low MemWrite is
// ignored and MemVal reads as zero. Reads carry no handshake: MemVal is valid
// combinationally whenever Ready is high.
interface memory_if;
    import mem_pkg::*;

    logic [15:0]       Address;
    logic [DATA_W-1:0] DataIn;
    logic              MemWrite;
    logic [DATA_W-1:0] MemVal;
    logic              Ready;

    modport master (
        output Address,
        output DataIn,
        output MemWrite,
        input  MemVal,
        input  Ready
    );

    modport slave (
        input  Address,
        input  DataIn,
        input  MemWrite,
        output MemVal,
        output Ready
    );

endinterface

// File: rtl/mem_array.sv
// Pure storage: synchronous write, asynchronous read (distributed RAM style).
module mem_array
    import mem_pkg::*;
#(
    parameter int DW = DATA_W,
    parameter int AW = ADDR_W
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    // One write port, updated on the rising edge when enabled.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/memory.sv
// 16-bit word RAM with a post-reset zero-fill sequencer and gated outputs.
module memory
    import mem_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    memory_if.slave    bus,
    output logic [0:0] debugState
);

    localparam logic [0:0]        stClear = CLEAR;
    localparam logic [0:0]        stRun   = RUN;
    localparam logic [ADDR_W-1:0] lastIdx = '1;

    logic [0:0]        state;
    logic [ADDR_W-1:0] clearPtr;
    logic              ready;

    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [ADDR_W-1:0] raddr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;

    // Clear sequencer: walk the pointer through every word, then enter RUN.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= stClear;
            clearPtr <= '0;
        end else if (state == stClear) begin
            clearPtr <= clearPtr + 1'b1;
            if (clearPtr == lastIdx) begin
                state <= stRun;
            end
        end
    end

    // Write port mux: the clear pointer owns the array until RUN; nothing is
    // written during a reset cycle, so a write coinciding with reset is lost.
    always_comb begin
        we    = 1'b0;
        waddr = memIndex(bus.Address);
        wdata = bus.DataIn;
        if (!reset) begin
            if (state == stClear) begin
                we    = 1'b1;
                waddr = clearPtr;
                wdata = '0;
            end else begin
                we = bus.MemWrite;
            end
        end
    end

    assign raddr = memIndex(bus.Address);

    mem_array #(
        .DW (DATA_W),
        .AW (ADDR_W)
    ) uArray (
        .clock (clock),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (raddr),
        .rdata (rdata)
    );

    assign ready      = (state == stRun);
    assign bus.Ready  = ready;
    assign bus.MemVal = ready ? rdata : '0;
    assign debugState = state;

endmodule

// File: tb/tb_memory.sv
// Directed bench for the memory block: reset/clear, sweeps, read-during-write,
// aliasing, write-enable low and reset mid-operation.
module tb_memory;

    logic        clock;
    logic        reset;
    logic [0:0]  debugState;

    memory_if bus ();

    memory dut (
        .clock      (clock),
        .reset      (reset),
        .bus        (bus),
        .debugState (debugState)
    );

    int          assertCount = 0;
    int          failCount   = 0;
    logic [15:0] model [1024];
    logic [15:0] expQ [$];

    // Clock generation.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkEq(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        assertCount++;
        assert (obs === expv) else begin
            failCount++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Synchronous write through the bus, mirrored into the model.
    task automatic writeWord(input logic [15:0] addr, input logic [15:0] data);
        bus.Address  = addr;
        bus.DataIn   = data;
        bus.MemWrite = 1'b1;
        tick();
        model[addr[9:0]] = data;
        bus.MemWrite = 1'b0;
    endtask

    // Combinational read: push expectation, settle, pop and compare.
    task automatic readAt(input string tag, input logic [15:0] addr);
        logic [15:0] e;
        bus.Address = addr;
        expQ.push_back(model[addr[9:0]]);
        #1;
        e = expQ.pop_front();
        checkEq(tag, bus.MemVal, e);
    endtask

    task automatic clearModel();
        for (int i = 0; i < 1024; i++) model[i] = 16'h0000;
    endtask

    initial begin
        logic earlyReady;
        int   waited;

        reset        = 1'b1;
        bus.Address  = 16'h0000;
        bus.DataIn   = 16'h0000;
        bus.MemWrite = 1'b0;
        clearModel();

        // Reset held for two edges.
        tick();
        tick();
        checkEq("resetReady", {15'h0, bus.Ready}, 16'h0000);
        checkEq("resetMemVal", bus.MemVal, 16'h0000);
        checkEq("resetState", {15'h0, debugState}, 16'h0000);

        // Release: Ready must stay low for 1023 edges and rise on the 1024th.
        reset = 1'b0;
        earlyReady = 1'b0;
        for (int e = 1; e < 1024; e++) begin
            tick();
            if (bus.Ready !== 1'b0) earlyReady = 1'b1;
            if (e == 512) checkEq("clearMemVal", bus.MemVal, 16'h0000);
        end
        checkEq("clearNoEarlyReady", {15'h0, earlyReady}, 16'h0000);
        tick();
        checkEq("clearReady", {15'h0, bus.Ready}, 16'h0001);
        checkEq("runState", {15'h0, debugState}, 16'h0001);

        readAt("zeroAddr4", 16'h0004);
        for (int i = 0; i < 1024; i++) readAt("zeroSweep", 16'(i));

        // Write sweep then readback.
        for (int i = 0; i < 64; i++) writeWord(16'(4 * i), 16'(i));
        for (int i = 0; i < 64; i++) readAt("sweepRead", 16'(4 * i));
        bus.Address = 16'd252;
        #1;
        checkEq("sweepAddr252", bus.MemVal, 16'd63);
        readAt("untouchedAddr2", 16'd2);

        // Read during write: old data before the edge, new data after.
        bus.Address  = 16'd8;
        bus.DataIn   = 16'hBEEF;
        bus.MemWrite = 1'b1;
        readAt("rdwOldData", 16'd8);
        readAt("rdwAddr9", 16'd9);
        bus.Address = 16'd8;
        tick();
        model[8] = 16'hBEEF;
        bus.MemWrite = 1'b0;
        #1;
        checkEq("rdwNewData", bus.MemVal, 16'hBEEF);

        // Aliasing: bit 10 and above are ignored.
        writeWord(16'h0005, 16'h1234);
        bus.Address = 16'h0405;
        #1;
        checkEq("aliasRead", bus.MemVal, 16'h1234);
        writeWord(16'hFC07, 16'h5A5A);
        readAt("aliasWriteHigh", 16'h0007);

        // Write enable low leaves the array untouched.
        writeWord(16'd12, 16'h00AA);
        bus.Address = 16'd12;
        bus.DataIn  = 16'hFFFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkEq("weLowHold", bus.MemVal, 16'h00AA);
        end

        // Reset mid-operation with a write pending: write is discarded.
        bus.Address  = 16'h0000;
        bus.DataIn   = 16'd7;
        bus.MemWrite = 1'b1;
        reset        = 1'b1;
        tick();
        reset = 1'b0;
        clearModel();
        checkEq("midResetReady", {15'h0, bus.Ready}, 16'h0000);
        checkEq("midResetState", {15'h0, debugState}, 16'h0000);
        checkEq("midResetMemVal", bus.MemVal, 16'h0000);
        waited = 0;
        while (bus.Ready !== 1'b1 && waited < 2000) begin
            tick();
            waited++;
            if (waited == 100) checkEq("midClearMemVal", bus.MemVal, 16'h0000);
        end
        checkEq("midClearLength", 16'(waited), 16'd1024);
        bus.MemWrite = 1'b0;
        for (int i = 0; i < 1024; i++) readAt("postClearZero", 16'(i));

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/memory.md
Name: memory

Overview:
- 16-bit word-wide data/instruction RAM for the 16-bit processor datapath.
- Synchronous write on the rising clock edge; combinational (asynchronous) read.
- After reset, a built-in clear sequencer zero-fills the array, so simulation and hardware start from a known state.
- Sits between the ALU/address path and the register-file write-back mux.

Parameters:
- DATA_W, 16, word width in bits.
- ADDR_W, 10, number of low address bits decoded; DEPTH = 2**ADDR_W words.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- Address  in  16  word address; only Address[ADDR_W-1:0] is decoded.
- DataIn  in  16  write data.
- MemWrite  in  1  write enable, sampled at the rising edge.
- MemVal  out  16  read data for the current Address.
- Ready  out  1  high when the clear sequence is done and accesses are honoured.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Addressing:
  - Word-addressed: index = Address[ADDR_W-1:0].
  - Upper bits [15:ADDR_W] are ignored, so addresses alias modulo DEPTH with no error flag.
- Write: at the rising edge, if Ready && MemWrite, then mem[index] <= DataIn. Latency is 1 edge.
- Read:
  - MemVal = mem[index], combinational, zero-cycle latency.
  - It follows Address changes within the same cycle.
  - After a write edge, MemVal shows the new word (the array output is simply re-evaluated).
- Same-address write and read in one cycle: MemVal shows the old data before the edge and DataIn after it.
- Clear sequencer (FSM states CLEAR, RUN):
  - reset=1 at an edge → state CLEAR, clear pointer = 0, Ready = 0.
  - In CLEAR, each edge writes mem[ptr] <= 0 and increments ptr. When ptr == DEPTH-1 is written → RUN, Ready = 1.
  - The clear therefore takes DEPTH cycles after reset deasserts: Ready rises on the DEPTH-th edge after the first edge with reset=0.
  - In RUN, stay until reset.
  - While reset is held, ptr stays 0 and no array writes occur.
- Reset values: Ready = 0, state = CLEAR, ptr = 0.
- MemVal while Ready=0 is forced to 16'h0000. MemWrite is ignored while Ready=0.
- Reset mid-clear or mid-operation restarts the clear from word 0. Any write in the reset cycle is discarded.
- Power-up before the first reset: state is undefined. The system requirement is to assert reset at least one edge before use.
- No X propagation from inputs into the array: when MemWrite is low, the array is untouched whatever DataIn is.

Decomposition:
- Shared package mem_pkg:
  - DATA_W and ADDR_W defaults.
  - State enum {CLEAR, RUN}.
  - Address-index helper function (truncate to ADDR_W).
- One natural sub-module: mem_array, a pure storage block.
  - Ports: clock, we, waddr, wdata, raddr, rdata.
  - Synchronous write, asynchronous read; infers distributed RAM.
- The top level holds the clear FSM, write-enable/address mux (clear pointer vs Address) and output gating.

Test Plan:
- Reset then clear: assert reset 2 cycles, release → Ready=0 for exactly 1024 edges, then 1. Every address reads 0; e.g. Address=16'h0004 → MemVal=16'h0000.
- Write/readback sweep: MemWrite=1, for i=0..63 set Address=4*i, DataIn=i, one cycle each. Then MemWrite=0 and re-sweep → MemVal=i at Address=4*i (e.g. Address=252 → 63); untouched Address=2 → 0.
- Write latency/read-during-write: Address=8, DataIn=16'hBEEF, MemWrite=1 → MemVal shows the old value (0) before the edge and 16'hBEEF after it. Change Address to 9 in the same cycle → immediate 0.
- Aliasing: write 16'h1234 at Address=16'h0005 → read at Address=16'h0405 (bit 10 set) returns 16'h1234.
- Write-enable low: Address=12 holds 16'h00AA; apply DataIn=16'hFFFF with MemWrite=0 for 3 edges → MemVal stays 16'h00AA.
- Reset mid-operation: after data is written, pulse reset for one cycle with MemWrite=1, Address=0, DataIn=7 → Ready drops, the write is discarded, MemVal=0 during the clear, all words are 0 after Ready returns.
